// File: rtl/comp_pkg.sv
// Shared encodings for the serial magnitude comparator:
// FSM states and the three-way decision result.
package comp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_HOLD  = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    RES_EQ = 2'b00,
    RES_GT = 2'b01,
    RES_LT = 2'b10
  } res_e;

endpackage

// File: rtl/comp_step.sv
// One MSB-first decision step: the first differing bit pair
// fixes the result, and every later pair leaves it alone.
module comp_step
  import comp_pkg::*;
(
  input  res_e prev_res,
  input  logic a_bit,
  input  logic b_bit,
  output res_e next_res
);

  always_comb begin
    next_res = prev_res;
    if (prev_res == RES_EQ && a_bit != b_bit) begin
      next_res = a_bit ? RES_GT : RES_LT;
    end
  end

endmodule

// File: rtl/serial_comp.sv
// Bit-serial unsigned comparator, MSB first, with a
// valid/ready result hold stage and restart-on-start.
module serial_comp
  import comp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       bit_valid,
  input  logic                       a_bit,
  input  logic                       b_bit,
  output logic                       busy,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic                       gt,
  output logic                       eq,
  output logic                       lt,
  output logic [$clog2(WIDTH+1)-1:0] bit_cnt
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e        state_q, state_d;
  res_e          dec_q, dec_d;
  res_e          step_res;
  logic [CW-1:0] cnt_q, cnt_d;

  comp_step u_step (
    .prev_res (dec_q),
    .a_bit    (a_bit),
    .b_bit    (b_bit),
    .next_res (step_res)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dec_d   = dec_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          dec_d   = RES_EQ;
        end
      end
      ST_SHIFT: begin
        // A start here wins over a same-cycle bit pair.
        if (start) begin
          cnt_d = '0;
          dec_d = RES_EQ;
        end else if (bit_valid) begin
          dec_d = step_res;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (res_ready) begin
          cnt_d   = '0;
          dec_d   = RES_EQ;
          state_d = start ? ST_SHIFT : ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        dec_d   = RES_EQ;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dec_q   <= RES_EQ;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dec_q   <= dec_d;
    end
  end

  assign busy      = (state_q == ST_SHIFT);
  assign res_valid = (state_q == ST_HOLD);
  assign gt        = res_valid && (dec_q == RES_GT);
  assign eq        = res_valid && (dec_q == RES_EQ);
  assign lt        = res_valid && (dec_q == RES_LT);
  assign bit_cnt   = cnt_q;

endmodule
